sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the board's single 16-bit async SRAM between the DLX instruction-fetch port and data port.
//  Each 32-bit access is sequenced as two 16-bit SRAM phases (low half, then high half).
//  Grants alternate round-robin between the ports. Sits between top/cpu and the SRAM pins, replacing direct sram_ctrl use.
// PARAMETERS
//  DATA_WIDTH  32  CPU word width; fixed at 2x SRAM width
//  ADDR_WIDTH  19  word address width; SRAM address = {addr, half}
//  WAIT_CYCLES 1   extra cycles per SRAM phase (phase length = WAIT_CYCLES+1, legal range 1..7)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-high
//  i_req         in   1   instruction read request; held high until i_ack
//  i_addr        in   19  instruction word address
//  i_rd_data     out  32  instruction read data
//  i_ack         out  1   one-cycle completion pulse, instruction port
//  d_req         in   1   data request; held high until d_ack
//  d_we          in   1   1 = write, 0 = read
//  d_addr        in   19  data word address
//  d_be          in   4   write byte enables (bit n -> bits 8n+7:8n); ignored on reads
//  d_wr_data     in   32  data write data
//  d_rd_data     out  32  data read data
//  d_ack         out  1   one-cycle completion pulse, data port
//  sram_addr     out  20  SRAM address
//  sram_ce_n/oe_n/we_n/ub_n/lb_n  out 1 each  SRAM strobes, active-low
//  sram_wr_data  out  16  SRAM write data
//  sram_dq_oe    out  1   1 = drive the DQ bus with sram_wr_data (top-level tristate)
//  sram_rd_data  in   16  SRAM DQ input
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: strobes 1, dq_oe 0, acks 0, sram_addr 0, sram_wr_data 0, rd_data regs 0.
//    The round-robin pointer resets to "last = D", so I wins the first tie.
//  - FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
//  - IDLE: with no requests, ce_n = 1. On any request, latch the winner, address, data and be; go to LO.
//  - Arbitration when both request in IDLE: the port not granted last wins. A lone request always wins.
//  - LO phase: sram_addr = {addr,0}, data bits 15:0. HI phase: sram_addr = {addr,1}, data bits 31:16.
//    Each phase lasts WAIT_CYCLES+1 cycles, timed by an internal counter; ce_n = 0 throughout.
//  - Read phase: oe_n = 0, we_n = 1, ub_n = lb_n = 0, dq_oe = 0.
//    The half-word is sampled on the phase's last cycle.
//  - Write phase: oe_n = 1 and dq_oe = 1 for the whole phase. we_n = 0 on all cycles except the last,
//    giving hold time before address changes. lb_n = !be[0|2] and ub_n = !be[1|3] for LO|HI.
//  - A write phase whose two byte enables are both 0 is skipped (0 cycles). If d_be == 0, go IDLE -> DONE directly.
//  - DONE: the granted port's ack = 1 for exactly 1 cycle; rd_data is updated in the same cycle.
//    rd_data holds until that port's next read ack. Strobes return to 1 in DONE.
//  - Latency, WAIT_CYCLES = 1, full access: request seen in IDLE at cycle T -> ack at T+5.
//    The next grant is decided in IDLE at T+6.
//  - A request dropped before ack is a protocol violation; the access still completes and acks.
//  - Address and data inputs are sampled only in IDLE. Changes while the port is pending are ignored.
//  - Reset mid-access: next edge forces IDLE and the reset values; no ack is issued, and the request is lost.
// STRUCTURE
//  - Shared defines include (the DE2-115 defines file) holds: FSM state encodings, SRAM_HALF_WIDTH = 16,
//    and the SRAM half-select bit position.
//  - Sub-module sram_rr_arb2: 2-requester round-robin with a last-grant register and update-on-grant input.
//  - The phase counter and FSM stay in this module.
// TESTING
//  1. Reset, then I-read at 0x00010 with SRAM model 0x00020 = 0xBEEF, 0x00021 = 0xDEAD
//     -> i_ack at T+5, i_rd_data = 0xDEADBEEF.
//  2. D-write 0x12345678 to 0x00003 with be = 4'b1111
//     -> 0x00006 = 0x5678, 0x00007 = 0x1234; we_n low 1 cycle per phase; d_ack once.
//  3. D-write with be = 4'b0100
//     -> only the HI phase runs, ub_n = 1, lb_n = 0, word 0x00007 low byte changes; ack at T+3.
//     With be = 0: no SRAM strobes, ack at T+1.
//  4. i_req and d_req held high together for 4 accesses
//     -> ack order I, D, I, D; neither port is starved; no cycle with both acks high.
//  5. Assert rst during the HI phase of a write
//     -> next cycle all strobes = 1, dq_oe = 0, no ack; a later request after reset completes normally.
//  6. WAIT_CYCLES = 3, D-read -> each phase lasts 4 cycles, ack at T+9, data sampled on the 4th cycle of each phase.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the two-port 16-bit SRAM arbiter: FSM encodings, SRAM geometry,
// and a helper that decides whether a 16-bit phase must run.
package sram_port_arbiter_pkg;

  localparam int SRAM_HALF_WIDTH = 16;
  localparam int SRAM_HALF_BIT   = 0;   // half-select is the SRAM address LSB

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Reads always run both halves; a write half with no enabled byte is skipped.
  function automatic logic half_active(input logic we, input logic [1:0] be_pair);
    return !we || (|be_pair);
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 = instruction port, bit 1 = data port.
// The last-grant register only moves when the owner commits a grant via update.
module sram_rr_arb2
  import sram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_reg;

  // On a tie the port that was not served last wins.
  assign grant[0] = req[0] && (!req[1] || (last_reg == PORT_D));
  assign grant[1] = req[1] && (!req[0] || (last_reg == PORT_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= PORT_D;
    end else if (update && (|grant)) begin
      last_reg <= grant[1];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 16-bit async SRAM between the instruction-fetch and data ports; every 32-bit
// access becomes a low-half then high-half SRAM phase, each WAIT_CYCLES+1 cycles long.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 19,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  output logic [DATA_WIDTH-1:0]      i_rd_data,
  output logic                       i_ack,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [ADDR_WIDTH-1:0]      d_addr,
  input  logic [3:0]                 d_be,
  input  logic [DATA_WIDTH-1:0]      d_wr_data,
  output logic [DATA_WIDTH-1:0]      d_rd_data,
  output logic                       d_ack,
  output logic [ADDR_WIDTH:0]        sram_addr,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic                       sram_ub_n,
  output logic                       sram_lb_n,
  output logic [SRAM_HALF_WIDTH-1:0] sram_wr_data,
  output logic                       sram_dq_oe,
  input  logic [SRAM_HALF_WIDTH-1:0] sram_rd_data
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  logic [1:0]                 state_reg, state_next;
  logic [2:0]                 cnt_reg, cnt_next;
  logic                       port_reg, we_reg;
  logic [ADDR_WIDTH-1:0]      addr_reg;
  logic [3:0]                 be_reg;
  logic [DATA_WIDTH-1:0]      wr_data_reg;
  logic [SRAM_HALF_WIDTH-1:0] lo_data_reg;

  logic [1:0]            req, grant;
  logic                  start, phase_end, half_next;
  logic                  cur_port, cur_we, lo_act, hi_act;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            cur_be;
  logic [DATA_WIDTH-1:0] cur_wr_data;

  assign req       = {d_req, i_req};
  assign start     = (state_reg == ST_IDLE) && (|req);
  assign phase_end = (cnt_reg == LAST_CNT);

  sram_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (start),
    .grant  (grant)
  );

  // In IDLE the access is taken straight from the winning port so the first phase's
  // strobes can be registered on the same edge that latches the request.
  always_comb begin
    cur_port    = port_reg;
    cur_we      = we_reg;
    cur_addr    = addr_reg;
    cur_be      = be_reg;
    cur_wr_data = wr_data_reg;
    if (state_reg == ST_IDLE) begin
      cur_port    = grant[1];
      cur_we      = grant[1] && d_we;
      cur_addr    = grant[1] ? d_addr : i_addr;
      cur_be      = grant[1] ? d_be : 4'hF;
      cur_wr_data = grant[1] ? d_wr_data : '0;
    end
    lo_act = half_active(cur_we, cur_be[1:0]);
    hi_act = half_active(cur_we, cur_be[3:2]);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cnt_next = '0;
          if (lo_act)      state_next = ST_LO;
          else if (hi_act) state_next = ST_HI;
          else             state_next = ST_DONE;
        end
      end
      ST_LO: begin
        if (phase_end) begin
          cnt_next   = '0;
          state_next = hi_act ? ST_HI : ST_DONE;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      ST_HI: begin
        if (phase_end) state_next = ST_DONE;
        else           cnt_next   = cnt_reg + 3'd1;
      end
      default: state_next = ST_IDLE;
    endcase
    half_next = (state_next == ST_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      port_reg     <= PORT_I;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      be_reg       <= '0;
      wr_data_reg  <= '0;
      lo_data_reg  <= '0;
      i_rd_data    <= '0;
      d_rd_data    <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      sram_addr    <= '0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_ub_n    <= 1'b1;
      sram_lb_n    <= 1'b1;
      sram_wr_data <= '0;
      sram_dq_oe   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;

      if (start) begin
        port_reg    <= cur_port;
        we_reg      <= cur_we;
        addr_reg    <= cur_addr;
        be_reg      <= cur_be;
        wr_data_reg <= cur_wr_data;
      end

      if ((state_reg == ST_LO) && phase_end) lo_data_reg <= sram_rd_data;

      // The high half is sampled on the final HI cycle, the same edge that raises ack.
      if ((state_next == ST_DONE) && (state_reg != ST_DONE)) begin
        if (cur_port == PORT_D) d_ack <= 1'b1;
        else                    i_ack <= 1'b1;
        if (!cur_we) begin
          if (cur_port == PORT_D) d_rd_data <= {sram_rd_data, lo_data_reg};
          else                    i_rd_data <= {sram_rd_data, lo_data_reg};
        end
      end

      if ((state_next == ST_LO) || (state_next == ST_HI)) begin
        sram_addr <= {cur_addr, half_next};
        sram_ce_n <= 1'b0;
        if (cur_we) begin
          sram_oe_n    <= 1'b1;
          sram_dq_oe   <= 1'b1;
          sram_we_n    <= (cnt_next == LAST_CNT);
          sram_lb_n    <= !(half_next ? cur_be[2] : cur_be[0]);
          sram_ub_n    <= !(half_next ? cur_be[3] : cur_be[1]);
          sram_wr_data <= half_next ? cur_wr_data[DATA_WIDTH-1:SRAM_HALF_WIDTH]
                                    : cur_wr_data[SRAM_HALF_WIDTH-1:0];
        end else begin
          sram_oe_n  <= 1'b0;
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
          sram_lb_n  <= 1'b0;
          sram_ub_n  <= 1'b0;
        end
      end else begin
        sram_ce_n  <= 1'b1;
        sram_oe_n  <= 1'b1;
        sram_we_n  <= 1'b1;
        sram_ub_n  <= 1'b1;
        sram_lb_n  <= 1'b1;
        sram_dq_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: SRAM behavioural model, scoreboard of expected
// acks, and one task per scenario (WAIT_CYCLES=1 instance plus a WAIT_CYCLES=3 instance).
module tb_sram_port_arbiter;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WAIT_CYCLES = 1 instance
  logic        i_req = 0, i_ack, d_req = 0, d_we = 0, d_ack;
  logic [18:0] i_addr = '0, d_addr = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_wr_data = '0, i_rd_data, d_rd_data;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe;
  logic [15:0] sram_wr_data, sram_rd_data;

  // WAIT_CYCLES = 3 instance
  logic        i3_req = 0, i3_ack, d3_req = 0, d3_ack;
  logic [18:0] i3_addr = '0, d3_addr = '0;
  logic [31:0] i3_rd_data, d3_rd_data;
  logic [19:0] sram_addr3;
  logic        ce3_n, oe3_n, we3_n, ub3_n, lb3_n, dq_oe3;
  logic [15:0] wr_data3, sram_rd_data3;
  logic [15:0] rd_xor = '0;

  logic [15:0] mem [0:255];
  logic        poke_en = 0;
  logic [7:0]  poke_addr = '0;
  logic [15:0] poke_val = '0;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  int ce_cnt = 0, we_cnt = 0, lo_ce_cnt = 0, i_ack_cnt = 0, d_ack_cnt = 0, both_cnt = 0;
  int ce3_cnt = 0;
  logic ub_seen = 1'b1, lb_seen = 1'b1;

  sram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(19), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rd_data(i_rd_data), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wr_data(d_wr_data),
    .d_rd_data(d_rd_data), .d_ack(d_ack),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_wr_data(sram_wr_data),
    .sram_dq_oe(sram_dq_oe), .sram_rd_data(sram_rd_data)
  );

  sram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(19), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i3_req), .i_addr(i3_addr), .i_rd_data(i3_rd_data), .i_ack(i3_ack),
    .d_req(d3_req), .d_we(1'b0), .d_addr(d3_addr), .d_be(4'h0), .d_wr_data(32'h0),
    .d_rd_data(d3_rd_data), .d_ack(d3_ack),
    .sram_addr(sram_addr3), .sram_ce_n(ce3_n), .sram_oe_n(oe3_n), .sram_we_n(we3_n),
    .sram_ub_n(ub3_n), .sram_lb_n(lb3_n), .sram_wr_data(wr_data3),
    .sram_dq_oe(dq_oe3), .sram_rd_data(sram_rd_data3)
  );

  // Async SRAM model: combinational read, byte-lane write while we_n is low.
  assign sram_rd_data  = mem[sram_addr[7:0]];
  assign sram_rd_data3 = mem[sram_addr3[7:0]] ^ rd_xor;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_val;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_wr_data[7:0];
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_wr_data[15:8];
    end
  end

  always @(negedge clk) begin
    if (!sram_ce_n) begin
      ce_cnt  <= ce_cnt + 1;
      ub_seen <= sram_ub_n;
      lb_seen <= sram_lb_n;
      if (!sram_addr[0]) lo_ce_cnt <= lo_ce_cnt + 1;
      if (!sram_we_n) we_cnt <= we_cnt + 1;
    end
    if (!ce3_n) ce3_cnt <= ce3_cnt + 1;
    if (i_ack) i_ack_cnt <= i_ack_cnt + 1;
    if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
    if (i_ack && d_ack) both_cnt <= both_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    poke_en = 1; poke_addr = a; poke_val = v;
    @(negedge clk);
    poke_en = 0;
  endtask

  // Drives one access on the WAIT_CYCLES=1 instance; lat = cycles from the IDLE cycle to ack.
  task automatic do_access(input bit port, input bit we, input logic [18:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           output bit got, output int lat, output logic [31:0] rdata);
    @(negedge clk);
    if (port) begin
      d_req = 1; d_we = we; d_addr = addr; d_be = be; d_wr_data = wdata;
    end else begin
      i_req = 1; i_addr = addr;
    end
    got = 0; lat = 0; rdata = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (port ? d_ack : i_ack) begin
        got = 1; lat = k; rdata = port ? d_rd_data : i_rd_data;
        break;
      end
    end
    i_req = 0; d_req = 0; d_we = 0;
    $display("txn port=%s we=%0d addr=%05h be=%b wdata=%08h got=%0d lat=%0d rdata=%08h",
             port ? "D" : "I", we, addr, be, wdata, got, lat, rdata);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      bad++; $display("FAIL reset_strobes got=%b want=11111",
                      {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    total++;
    if ({sram_dq_oe, i_ack, d_ack} !== 3'b000) begin
      bad++; $display("FAIL reset_oe_acks got=%b want=000", {sram_dq_oe, i_ack, d_ack});
    end
    total++;
    if ({sram_addr, sram_wr_data, i_rd_data, d_rd_data} !== '0) begin
      bad++; $display("FAIL reset_regs got addr=%h wr=%h i_rd=%h d_rd=%h want all 0",
                      sram_addr, sram_wr_data, i_rd_data, d_rd_data);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    bit got; int lat; logic [31:0] rd; exp_t e;
    poke(8'h20, 16'hBEEF);
    poke(8'h21, 16'hDEAD);
    e.port = 0; e.data = 32'hDEADBEEF; e.lat = 5; exp_q.push_back(e);
    do_access(0, 0, 19'h00010, 4'hF, 32'h0, got, lat, rd);
    e = exp_q.pop_front();
    total++;
    if (!got || lat !== e.lat) begin
      bad++; $display("FAIL i_read_latency got=%0d (ack=%0d) want=%0d", lat, got, e.lat);
    end
    total++;
    if (rd !== e.data) begin
      bad++; $display("FAIL i_read_data got=%h want=%h", rd, e.data);
    end
  endtask

  task automatic test_d_write_full();
    bit got; int lat; logic [31:0] rd; exp_t e; int we0, da0;
    we0 = we_cnt; da0 = d_ack_cnt;
    e.port = 1; e.data = 32'h0; e.lat = 5; exp_q.push_back(e);
    do_access(1, 1, 19'h00003, 4'b1111, 32'h12345678, got, lat, rd);
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (!got || lat !== e.lat) begin
      bad++; $display("FAIL d_write_latency got=%0d (ack=%0d) want=%0d", lat, got, e.lat);
    end
    total++;
    if ({mem[6], mem[7]} !== {16'h5678, 16'h1234}) begin
      bad++; $display("FAIL d_write_mem got=%h_%h want=5678_1234", mem[6], mem[7]);
    end
    total++;
    if (we_cnt - we0 !== 2) begin
      bad++; $display("FAIL d_write_we_cycles got=%0d want=2", we_cnt - we0);
    end
    total++;
    if (d_ack_cnt - da0 !== 1) begin
      bad++; $display("FAIL d_write_ack_count got=%0d want=1", d_ack_cnt - da0);
    end
  endtask

  task automatic test_partial_be();
    bit got; int lat; logic [31:0] rd; exp_t e; int lo0, ce0;
    lo0 = lo_ce_cnt;
    e.port = 1; e.data = 32'h0; e.lat = 3; exp_q.push_back(e);
    do_access(1, 1, 19'h00003, 4'b0100, 32'hAABBCCDD, got, lat, rd);
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (!got || lat !== e.lat) begin
      bad++; $display("FAIL be0100_latency got=%0d (ack=%0d) want=%0d", lat, got, e.lat);
    end
    total++;
    if ({lo_ce_cnt - lo0, ub_seen, lb_seen} !== {32'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL be0100_strobes got lo_cycles=%0d ub_n=%b lb_n=%b want 0 1 0",
                      lo_ce_cnt - lo0, ub_seen, lb_seen);
    end
    total++;
    if ({mem[6], mem[7]} !== {16'h5678, 16'h12BB}) begin
      bad++; $display("FAIL be0100_mem got=%h_%h want=5678_12bb", mem[6], mem[7]);
    end
    ce0 = ce_cnt;
    e.port = 1; e.data = 32'h0; e.lat = 1; exp_q.push_back(e);
    do_access(1, 1, 19'h00003, 4'b0000, 32'h0, got, lat, rd);
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (!got || lat !== e.lat) begin
      bad++; $display("FAIL be0000_latency got=%0d (ack=%0d) want=%0d", lat, got, e.lat);
    end
    total++;
    if (ce_cnt - ce0 !== 0) begin
      bad++; $display("FAIL be0000_no_strobes got ce_cycles=%0d want=0", ce_cnt - ce0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int seen, b0;
    logic [31:0] want_i, want_d;
    want_i = 32'hDEADBEEF; want_d = 32'h12BB5678;
    b0 = both_cnt;
    for (int n = 0; n < 4; n++) begin
      e.port = n[0]; e.data = n[0] ? want_d : want_i; e.lat = 0; exp_q.push_back(e);
    end
    @(negedge clk);
    i_req = 1; i_addr = 19'h00010;
    d_req = 1; d_we = 0; d_addr = 19'h00003; d_be = 4'hF;
    seen = 0;
    for (int k = 0; k < 60 && seen < 4; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        e = exp_q.pop_front();
        seen++;
        $display("txn rr ack#%0d port=%s data=%08h", seen, d_ack ? "D" : "I",
                 d_ack ? d_rd_data : i_rd_data);
        total++;
        if (d_ack !== e.port) begin
          bad++; $display("FAIL rr_order ack#%0d got port=%0d want=%0d", seen, d_ack, e.port);
        end
        total++;
        if ((d_ack ? d_rd_data : i_rd_data) !== e.data) begin
          bad++; $display("FAIL rr_data ack#%0d got=%h want=%h", seen,
                          d_ack ? d_rd_data : i_rd_data, e.data);
        end
      end
    end
    i_req = 0; d_req = 0;
    total++;
    if (seen != 4) begin
      bad++; $display("FAIL rr_ack_count got=%0d want=4", seen);
      exp_q.delete();
    end
    @(negedge clk);
    total++;
    if (both_cnt - b0 !== 0) begin
      bad++; $display("FAIL rr_both_acks got=%0d cycles want=0", both_cnt - b0);
    end
  endtask

  task automatic test_reset_mid_access();
    bit got; int lat; logic [31:0] rd; exp_t e; int da0;
    da0 = d_ack_cnt;
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 19'h00008; d_be = 4'hF; d_wr_data = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    total++;
    if ({sram_ce_n, sram_addr[0]} !== 2'b01) begin
      bad++; $display("FAIL rst_mid_in_hi got ce_n=%b half=%b want 0 1", sram_ce_n, sram_addr[0]);
    end
    rst = 1;
    @(negedge clk);
    total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, d_ack} !== 7'b1111100) begin
      bad++; $display("FAIL rst_mid_outputs got=%b want=1111100",
                      {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, d_ack});
    end
    rst = 0; d_req = 0; d_we = 0;
    repeat (8) @(negedge clk);
    total++;
    if (d_ack_cnt - da0 !== 0) begin
      bad++; $display("FAIL rst_mid_no_ack got=%0d acks want=0", d_ack_cnt - da0);
    end
    e.port = 0; e.data = 32'hDEADBEEF; e.lat = 5; exp_q.push_back(e);
    do_access(0, 0, 19'h00010, 4'hF, 32'h0, got, lat, rd);
    e = exp_q.pop_front();
    total++;
    if (!got || lat !== e.lat || rd !== e.data) begin
      bad++; $display("FAIL rst_mid_recover got ack=%0d lat=%0d data=%h want lat=%0d data=%h",
                      got, lat, rd, e.lat, e.data);
    end
  endtask

  task automatic test_wait3();
    exp_t e; bit got; int lat, ce0;
    logic [31:0] rd;
    poke(8'h60, 16'h1111);
    poke(8'h61, 16'h2222);
    ce0 = ce3_cnt;
    e.port = 1; e.data = 32'h22221111; e.lat = 9; exp_q.push_back(e);
    @(negedge clk);
    d3_req = 1; d3_addr = 19'h00030;
    got = 0; lat = 0; rd = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (d3_ack) begin
        got = 1; lat = k; rd = d3_rd_data;
        break;
      end
      // Corrupt read data on every cycle except the final cycle of each phase.
      rd_xor = (k == 4 || k == 8) ? 16'h0000 : 16'hFFFF;
    end
    rd_xor = '0; d3_req = 0;
    $display("txn wait3 port=D addr=00030 got=%0d lat=%0d rdata=%08h", got, lat, rd);
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (!got || lat !== e.lat) begin
      bad++; $display("FAIL wait3_latency got=%0d (ack=%0d) want=%0d", lat, got, e.lat);
    end
    total++;
    if (rd !== e.data) begin
      bad++; $display("FAIL wait3_data got=%h want=%h", rd, e.data);
    end
    total++;
    if (ce3_cnt - ce0 !== 8) begin
      bad++; $display("FAIL wait3_phase_cycles got=%0d want=8", ce3_cnt - ce0);
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write_full();
    test_partial_be();
    test_back_to_back();
    test_reset_mid_access();
    test_wait3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
